divider: RTL and testbench



---
 rtl/div_pkg.sv | 15 +
 rtl/divstep.sv | 26 ++
 rtl/divider.sv | 119 +++++++++++
 tb/tb_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle integer divide unit.
package div_pkg;

  localparam int DIV_W = 32;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIXUP,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/divstep.sv
// One combinational radix-2 restoring division step: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference on no borrow.
module divstep
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] vmag,
  output logic [DIV_W-1:0] rem_next,
  output logic [DIV_W-1:0] quo_next
);

  logic [DIV_W:0] t;

  always_comb begin
    t = {rem, quo[DIV_W-1]} - {1'b0, vmag};
    if (!t[DIV_W]) begin
      rem_next = t[DIV_W-1:0];
      quo_next = {quo[DIV_W-2:0], 1'b1};
    end else begin
      rem_next = {rem[DIV_W-2:0], quo[DIV_W-1]};
      quo_next = {quo[DIV_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Multicycle 32/32 signed/unsigned divider for the execute stage. Stalls EX
// via hold_next until the registered quotient/remainder are valid.
module divider
  import div_pkg::*;
(
  input  logic        nGCLK,
  input  logic        reset,
  input  logic        nWAIT,
  input  logic        enable,
  input  logic        u,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero,
  output logic        done,
  output logic        hold_next
);

  function automatic logic [DIV_W-1:0] cond_neg(input logic neg, input logic [DIV_W-1:0] v);
    return neg ? (~v + DIV_W'(1)) : v;
  endfunction

  // Leading all-zero bytes, clamped to 3 so at least one byte is always computed.
  function automatic logic [1:0] lead_zero_bytes(input logic [DIV_W-1:0] v);
    if (v[31:8] == '0)       return 2'd3;
    else if (v[31:16] == '0) return 2'd2;
    else if (v[31:24] == '0) return 2'd1;
    return 2'd0;
  endfunction

  div_state_t state, state_next;

  logic [DIV_W-1:0] vmag, rem, quo;
  logic [DIV_W-1:0] rem_next, quo_next;
  logic [DIV_W-1:0] dmag_in, vmag_in;
  logic [1:0]       nz;
  logic [4:0]       cnt;
  logic             qneg, rneg;
  logic             op2_zero;

  assign op2_zero = (op2 == '0);
  assign dmag_in  = cond_neg(~u & op1[31], op1);
  assign vmag_in  = cond_neg(~u & op2[31], op2);
  assign nz       = lead_zero_bytes(dmag_in);

  divstep u_divstep (
    .rem      (rem),
    .quo      (quo),
    .vmag     (vmag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge nGCLK) begin
    if (reset)      state <= DIV_IDLE;
    else if (nWAIT) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE:  if (enable) state_next = op2_zero ? DIV_DONE : DIV_CALC;
      DIV_CALC: begin
        if (!enable)          state_next = DIV_IDLE;
        else if (cnt == 5'd31) state_next = DIV_FIXUP;
      end
      DIV_FIXUP: state_next = enable ? DIV_DONE : DIV_IDLE;
      DIV_DONE:  state_next = DIV_IDLE;
      default:   state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    done      = (state == DIV_DONE);
    hold_next = enable & ~reset & (state != DIV_DONE);
  end

  // Accept: latch magnitudes and skip leading zero bytes; calc: one step per cycle.
  always_ff @(posedge nGCLK) begin
    if (nWAIT) begin
      if (state == DIV_IDLE) begin
        vmag <= vmag_in;
        qneg <= ~u & (op1[31] ^ op2[31]);
        rneg <= ~u & op1[31];
        cnt  <= {nz, 3'b000};
        rem  <= '0;
        quo  <= dmag_in << {nz, 3'b000};
      end else if (state == DIV_CALC) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + 5'd1;
      end
    end
  end

  // Result registers: only updated by an accepted divide, held across aborts.
  always_ff @(posedge nGCLK) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (nWAIT) begin
      if (state == DIV_IDLE && enable) begin
        if (op2_zero) begin
          quotient  <= DIV_ZERO_QUO;
          remainder <= op1;
          div_zero  <= 1'b1;
        end else begin
          div_zero  <= 1'b0;
        end
      end else if (state == DIV_FIXUP && enable) begin
        quotient  <= cond_neg(qneg, quo);
        remainder <= cond_neg(rneg, rem);
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a negedge
// monitor pops and compares whenever done is presented.
module tb_divider;

  logic        nGCLK;
  logic        reset;
  logic        nWAIT;
  logic        enable;
  logic        u;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;
  logic        done;
  logic        hold_next;

  divider dut (
    .nGCLK     (nGCLK),
    .reset     (reset),
    .nWAIT     (nWAIT),
    .enable    (enable),
    .u         (u),
    .op1       (op1),
    .op2       (op2),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .done      (done),
    .hold_next (hold_next)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic        last_dz = 1'b0;

  initial nGCLK = 1'b0;
  always #5 nGCLK = ~nGCLK;

  always @(posedge nGCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge nGCLK) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_zero", 32'(div_zero), 32'(mon_e.dz));
        check("hold_in_done", 32'(hold_next), 32'd0);
        if (mon_e.due >= 0) check("latency_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // lat < 0 skips the latency comparison for that vector.
  task automatic run_div(input logic uu, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int lat, input int st_at, input int st_len);
    int base;
    int n;
    @(posedge nGCLK); #1;
    enable = 1'b1; u = uu; op1 = a; op2 = b; nWAIT = 1'b1;
    base = cyc;
    sb_q.push_back('{q: eq, r: er, dz: edz, due: (lat < 0) ? -1 : base + lat + st_len});
    @(negedge nGCLK);
    check("hold_accept", 32'(hold_next), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge nGCLK); #1;
      n++;
      nWAIT = !(st_len > 0 && n >= st_at && n < st_at + st_len);
      @(negedge nGCLK);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      sb_q.delete();
    end
    last_q = eq; last_r = er; last_dz = edz;
    @(posedge nGCLK); #1;
    enable = 1'b0; nWAIT = 1'b1;
  endtask

  task automatic run_abort(input bit use_reset);
    @(posedge nGCLK); #1;
    enable = 1'b1; u = 1'b1; op1 = 32'hFFFFFFFF; op2 = 32'd16; nWAIT = 1'b1;
    repeat (12) begin
      @(posedge nGCLK); #1;
    end
    if (use_reset) reset = 1'b1;
    else           enable = 1'b0;
    @(negedge nGCLK);
    check("abort_hold", 32'(hold_next), 32'd0);
    @(posedge nGCLK); #1;
    reset = 1'b0; enable = 1'b0;
    @(negedge nGCLK);
    check("abort_quotient", quotient, use_reset ? 32'd0 : last_q);
    check("abort_remainder", remainder, use_reset ? 32'd0 : last_r);
    check("abort_div_zero", 32'(div_zero), use_reset ? 32'd0 : 32'(last_dz));
    repeat (3) begin
      @(negedge nGCLK);
      check("abort_no_done", 32'(done), 32'd0);
    end
    if (use_reset) begin
      last_q = '0; last_r = '0; last_dz = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; nWAIT = 1'b1; enable = 1'b1; u = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge nGCLK);
    @(negedge nGCLK);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_div_zero", 32'(div_zero), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hold", 32'(hold_next), 32'd0);
    @(posedge nGCLK); #1;
    reset = 1'b0; enable = 1'b0;

    run_div(1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 10, 0, 0);
    run_div(1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, -1, 0, 0);
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 34, 0, 0);
    run_div(1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 1,  0, 0);
    run_div(1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34, 0, 0);
    run_div(1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 10, 0, 0);
    run_div(1'b1, 32'h00012345,   32'h100,        32'h123,        32'h45,         1'b0, 26, 0, 0);
    run_div(1'b1, 32'h00001234,   32'h10,         32'h123,        32'd4,          1'b0, 18, 0, 0);
    run_div(1'b1, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15,         1'b0, 34, 10, 5);

    run_abort(1'b0);
    run_abort(1'b1);

    run_div(1'b0, 32'd50,         32'hFFFFFFFB,   32'hFFFFFFF6,   32'd0,          1'b0, 10, 0, 0);

    repeat (3) @(negedge nGCLK);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
